// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the MIPS control unit and the
// sequential divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  lo, hi, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output lo, hi, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Sequential signed restoring divider for DIV: quotient to LO, remainder to HI.
// One quotient bit per cycle on operand magnitudes, signs restored at the end.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             step_ge;

    // Datapath for one restoring step; the shifted remainder needs WIDTH+1
    // bits so the compare cannot overflow when |divisor| has its MSB set.
    always_comb begin
        dvd_abs  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_abs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        step_ge  = (rem_sh >= {1'b0, dvs_q});
        rem_step = step_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], step_ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        // Divide by zero: skip RUN, leave LO/HI untouched.
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        quo_d    = dvd_abs;
                        dvs_d    = dvs_abs;
                        rem_d    = '0;
                        cnt_d    = '0;
                        sign_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r_d = bus.dividend[WIDTH-1];
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    lo_d       = sign_q_q ? -quo_step : quo_step;
                    hi_d       = sign_r_q ? -rem_step : rem_step;
                    div_zero_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.lo       = lo_q;
    assign bus.hi       = hi_q;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic/latency reference model checked every cycle,
// plus directed operations with literal expected results.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    div_unit_if #(.WIDTH(32)) u_if ();

    div_unit #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic in 64-bit signed: truncating division, remainder
    // follows the dividend; the 0x80000000/-1 case wraps when truncated.
    function automatic logic [31:0] ref_quo(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q  = sa / sb;
        return q[31:0];
    endfunction

    function automatic logic [31:0] ref_rem(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = sa % sb;
        return r[31:0];
    endfunction

    // Timing model: an accepted nonzero division completes 32 edges after
    // acceptance; a zero divisor completes on the accepting edge itself.
    logic [31:0] m_lo, m_hi, p_lo, p_hi;
    logic        m_done, m_dz;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lo   <= '0;
            m_hi   <= '0;
            p_lo   <= '0;
            p_hi   <= '0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_lo   <= p_lo;
                m_hi   <= p_hi;
                m_dz   <= 1'b0;
            end
        end else if (u_if.start) begin
            if (u_if.divisor == 32'd0) begin
                m_done <= 1'b1;
                m_dz   <= 1'b1;
            end else begin
                m_left <= 32;
                p_lo   <= ref_quo(u_if.dividend, u_if.divisor);
                p_hi   <= ref_rem(u_if.dividend, u_if.divisor);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_lo",       u_if.lo,                m_lo);
        chk("cyc_hi",       u_if.hi,                m_hi);
        chk("cyc_done",     32'(u_if.done),         32'(m_done));
        chk("cyc_busy",     32'(u_if.busy),         32'(m_left > 0));
        chk("cyc_div_zero", 32'(u_if.div_zero),     32'(m_dz));
    end

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edz, input int elat);
        int n;
        @(posedge clk);
        #1;
        u_if.start    = 1'b1;
        u_if.dividend = a;
        u_if.divisor  = b;
        @(posedge clk);
        #1;
        u_if.start    = 1'b0;
        u_if.dividend = 32'hDEAD_BEEF;
        u_if.divisor  = 32'h0000_0003;
        n = 1;
        while (!u_if.done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(elat));
        chk({name, "_lo"}, u_if.lo, elo);
        chk({name, "_hi"}, u_if.hi, ehi);
        chk({name, "_dz"}, 32'(u_if.div_zero), 32'(edz));
        $display("op %-10s %h / %h -> lo=%h hi=%h dz=%0d edges=%0d", name, a, b,
                 u_if.lo, u_if.hi, u_if.div_zero, n);
    endtask

    logic [31:0] hs_a [6];
    logic [31:0] hs_b [6];

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        u_if.start    = 1'b0;
        u_if.dividend = '0;
        u_if.divisor  = '0;
        hs_a = '{32'd1000, 32'hFFFF_FF9C, 32'd77, 32'd5, 32'h8000_0000, 32'd12345};
        hs_b = '{32'd3,    32'd7,         32'd0,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd10};

        #12;
        chk("rst_lo",   u_if.lo,              32'd0);
        chk("rst_hi",   u_if.hi,              32'd0);
        chk("rst_busy", 32'(u_if.busy),       32'd0);
        chk("rst_done", 32'(u_if.done),       32'd0);
        chk("rst_dz",   32'(u_if.div_zero),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op("basic",   32'd100,       32'd7,          32'd14,        32'd2,         1'b0, 33);
        do_op("neg_dvd", 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        do_op("neg_dvs", 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2, 32'd2,         1'b0, 33);
        do_op("neg_both",32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0, 33);
        do_op("overflow",32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 33);
        do_op("zero_dvd",32'd0,         32'd5,          32'd0,         32'd0,         1'b0, 33);
        do_op("small",   32'd7,         32'd100,        32'd0,         32'd7,         1'b0, 33);
        do_op("maxpos",  32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 32'd0,         1'b0, 33);
        do_op("big_dvs", 32'hFFFF_FFFF, 32'h8000_0000,  32'd0,         32'hFFFF_FFFF, 1'b0, 33);
        do_op("pre_dz",  32'd23,        32'd4,          32'd5,         32'd3,         1'b0, 33);
        do_op("div_zero",32'd42,        32'd0,          32'd5,         32'd3,         1'b1, 1);

        // Abort 1000/3 with an asynchronous reset partway through RUN.
        @(posedge clk);
        #1;
        u_if.start    = 1'b1;
        u_if.dividend = 32'd1000;
        u_if.divisor  = 32'd3;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_lo",   u_if.lo,            32'd0);
        chk("abort_hi",   u_if.hi,            32'd0);
        chk("abort_busy", 32'(u_if.busy),     32'd0);
        chk("abort_done", 32'(u_if.done),     32'd0);
        chk("abort_dz",   32'(u_if.div_zero), 32'd0);
        $display("op abort     reset during RUN -> lo=%h hi=%h busy=%0d", u_if.lo, u_if.hi, u_if.busy);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op("post_rst", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);

        // start held high with operands changing every cycle.
        for (int i = 0; i < 140; i++) begin
            u_if.start    = 1'b1;
            u_if.dividend = hs_a[i % 6];
            u_if.divisor  = hs_b[i % 6];
            @(posedge clk);
            #1;
            if (u_if.done)
                $display("op hold      done lo=%h hi=%h dz=%0d", u_if.lo, u_if.hi, u_if.div_zero);
        end
        u_if.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_busy", 32'(u_if.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath, implementing DIV.
- Sits directly downstream of the operand-B select stage: it consumes register A as the dividend and the selected operand-B value as the divisor.
- Produces the quotient (LO) and remainder (HI) for the HI/LO registers.
- Uses a start/done handshake with the control unit, which stalls while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  WIDTH  signed dividend (register A).
- divisor  in  WIDTH  signed divisor (operand-B value).
- lo  out  WIDTH  quotient.
- hi  out  WIDTH  remainder.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  divisor was zero on the last accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - lo=0, hi=0, busy=0, done=0, div_zero=0.
  - Counter and internal registers cleared.
  - Reset asserted mid-RUN aborts the operation immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1 and divisor!=0:
    - Latch |dividend| and |divisor| (two's-complement magnitudes).
    - Latch sign_q = dividend[31] XOR divisor[31] and sign_r = dividend[31].
    - Clear the partial remainder, set the counter to 0, go to RUN.
  - On a rising edge with start=1 and divisor==0:
    - Go to DONE, set div_zero=1.
    - lo and hi keep their previous values.
  - On a rising edge with start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge performs one restoring-division step: shift {rem, quo} left by 1; if rem >= |divisor|, subtract and set quo[0]=1.
  - Exactly WIDTH steps.
  - On the edge completing step WIDTH:
    - lo = sign_q ? -quo : quo.
    - hi = sign_r ? -rem : rem.
    - div_zero=0, go to DONE.
  - start is ignored while in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge returns to IDLE unconditionally; start is ignored during DONE.
  - A back-to-back start is accepted in the following IDLE cycle.
- Latency:
  - Nonzero divisor: done is high in the cycle after WIDTH+1 rising edges counted from the edge that sampled start (33 edges for WIDTH=32).
  - Zero divisor: done is high in the cycle immediately after the sampling edge.
- Output hold: lo, hi and div_zero hold their values until the next operation completes or reset asserts.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend, so dividend = quotient*divisor + remainder.
  - Internal magnitudes are WIDTH-bit unsigned; the comparison and subtraction use WIDTH+1 bits to avoid overflow.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (magnitude wrap); no flag is raised.
  - Dividend 0 with a nonzero divisor yields lo=0, hi=0 and full latency.
- Operand stability: dividend and divisor are needed only on the start edge; later changes have no effect.

Test Plan:
- Basic: dividend=100, divisor=7, start pulse -> busy for 32 cycles, then done=1 with lo=14, hi=2; done high for exactly one cycle.
- Signs: -100/7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); 100/-7 -> lo=-14, hi=2; -100/-7 -> lo=14, hi=-2.
- Divide by zero: lo=5, hi=3 from a prior operation, then start with dividend=42, divisor=0 -> next cycle done=1, div_zero=1, lo=5, hi=3, busy never high.
- Overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0, done after 33 edges.
- Handshake: hold start=1 continuously with operands changing every cycle -> only the operands on accepted start edges are used; each result is followed by one DONE cycle and a new acceptance in the next IDLE cycle; start pulses during RUN are ignored.
- Reset mid-operation: assert reset=0 asynchronously at RUN step 10 of 1000/3 -> all outputs 0 immediately, no done pulse; after release, 9/4 -> lo=2, hi=1.
